// File: rtl/fp_arb_pkg.sv
// Purpose : shared types and constants for the FP32 adder arbiter slice.
// Contents: FSM state enum, FP word width, quiet-NaN pattern, sign bit index.
// Users   : fp_add_arbiter_if, fp_add_arbiter, rr_pick.
package fp_arb_pkg;

  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Purpose : bundles the requester side and the adder-core side of the arbiter.
// Ports   : req_valid/req_sub/req_a/req_b in, req_ready/resp_* out (requesters);
//           fpu_start/fpu_a/fpu_b out, fpu_result/fpu_finish in (adder core); busy out.
//           slave = arbiter view, master = requesters + core view.
interface fp_add_arbiter_if
  import fp_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_sub;
  logic [FP_W*N_REQ-1:0] req_a;
  logic [FP_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      resp_valid;
  logic [FP_W-1:0]       resp_data;
  logic                  resp_timeout;
  logic                  busy;
  logic                  fpu_start;
  logic [FP_W-1:0]       fpu_a;
  logic [FP_W-1:0]       fpu_b;
  logic [FP_W-1:0]       fpu_result;
  logic                  fpu_finish;

  modport slave (
    input  req_valid, req_sub, req_a, req_b, fpu_result, fpu_finish,
    output req_ready, resp_valid, resp_data, resp_timeout, busy,
           fpu_start, fpu_a, fpu_b
  );

  modport master (
    output req_valid, req_sub, req_a, req_b, fpu_result, fpu_finish,
    input  req_ready, resp_valid, resp_data, resp_timeout, busy,
           fpu_start, fpu_a, fpu_b
  );

endinterface

// File: rtl/rr_pick.sv
// Purpose : rotating-priority picker; returns the first set request at or after
//           i_ptr, wrapping to index 0. Purely combinational, no backpressure.
// Ports   : i_req[N] requests, i_ptr start index -> o_found any set, o_idx winner.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic          w_hi_vld;
  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;

  // Lowest set index at/above the pointer wins; otherwise wrap to the lowest set
  // index overall. Scanning downwards leaves the lowest match in each variable.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_idx = IW'(i);
        if (IW'(i) >= i_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_idx = IW'(i);
        end
      end
    end
  end

  assign o_found = |i_req;
  assign o_idx   = w_hi_vld ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/fp_add_arbiter.sv
// Purpose : shares one multi-cycle FP32 adder among N_REQ requesters, round-robin,
//           with operand capture, subtract via B sign flip and a timeout guard.
// Latency : request seen -> resp_valid = 3 cycles + core latency; TIMEOUT WAIT
//           cycles max, then a qNaN response flagged by resp_timeout.
// Backpr. : one transaction at a time; other requesters hold req_valid until
//           their req_ready pulse. Dropping req_valid before grant withdraws it.
// Ports   : clk, rst (async, active-high), arb_if (fp_add_arbiter_if.slave).
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_add_arbiter_if.slave      arb_if
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gnt;
  logic [CW-1:0]    r_cnt;
  logic [FP_W-1:0]  r_fpu_a;
  logic [FP_W-1:0]  r_fpu_b;
  logic [FP_W-1:0]  r_resp_data;
  logic [N_REQ-1:0] r_req_ready;
  logic [N_REQ-1:0] r_resp_valid;
  logic             r_fpu_start;
  logic             r_timeout;
  logic             r_busy;

  logic             w_found;
  logic [IW-1:0]    w_idx;
  logic [FP_W-1:0]  w_cap_a;
  logic [FP_W-1:0]  w_cap_b;
  logic [N_REQ-1:0] w_ready_nxt;
  logic [N_REQ-1:0] w_resp_vld_nxt;
  logic             w_start_nxt;
  logic             w_cap;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_fin;
  logic             w_to;
  logic             w_ptr_adv;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req   (arb_if.req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Operand mux for the winner; subtract is folded in as a raw sign-bit flip of B.
  always_comb begin
    w_cap_a = '0;
    w_cap_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_cap_a = arb_if.req_a[FP_W*i +: FP_W];
        w_cap_b = arb_if.req_b[FP_W*i +: FP_W];
        w_cap_b[FP_SIGN_BIT] = w_cap_b[FP_SIGN_BIT] ^ arb_if.req_sub[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state plus next values of the registered pulse outputs, so every output
  // lines up with the state it belongs to.
  always_comb begin
    w_state_nxt    = r_state;
    w_ready_nxt    = '0;
    w_resp_vld_nxt = '0;
    w_start_nxt    = 1'b0;
    w_cap          = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_inc      = 1'b0;
    w_fin          = 1'b0;
    w_to           = 1'b0;
    w_ptr_adv      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt        = ISSUE;
          w_cap              = 1'b1;
          w_start_nxt        = 1'b1;
          w_ready_nxt[w_idx] = 1'b1;
        end
      end
      ISSUE: begin
        // fpu_finish may still be high from the previous job here; not sampled.
        w_state_nxt = WAIT;
        w_cnt_clr   = 1'b1;
      end
      WAIT: begin
        if (arb_if.fpu_finish) begin
          w_state_nxt           = RESP;
          w_fin                 = 1'b1;
          w_resp_vld_nxt[r_gnt] = 1'b1;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt           = RESP;
          w_to                  = 1'b1;
          w_resp_vld_nxt[r_gnt] = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_ptr_adv   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_resp_data  <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_fpu_start  <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_req_ready  <= w_ready_nxt;
      r_resp_valid <= w_resp_vld_nxt;
      r_fpu_start  <= w_start_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      if (w_cap) begin
        r_fpu_a <= w_cap_a;
        r_fpu_b <= w_cap_b;
        r_gnt   <= w_idx;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_fin) begin
        r_resp_data <= arb_if.fpu_result;
        r_timeout   <= 1'b0;
      end else if (w_to) begin
        r_resp_data <= FP_QNAN;
        r_timeout   <= 1'b1;
      end else if (w_ptr_adv) begin
        r_timeout   <= 1'b0;
      end
      if (w_ptr_adv) r_ptr <= (r_gnt == IW'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

  assign arb_if.req_ready    = r_req_ready;
  assign arb_if.resp_valid   = r_resp_valid;
  assign arb_if.resp_data    = r_resp_data;
  assign arb_if.resp_timeout = r_timeout;
  assign arb_if.busy         = r_busy;
  assign arb_if.fpu_start    = r_fpu_start;
  assign arb_if.fpu_a        = r_fpu_a;
  assign arb_if.fpu_b        = r_fpu_b;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter with a table-driven adder core stub (fixed latency,
// optional hang), directed vectors, hand-computed results.
module tb_fp_add_arbiter;

  localparam int N        = 4;
  localparam int TMO      = 8;
  localparam int CORE_LAT = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   core_cnt;
  bit   core_hang;
  logic [31:0] core_a;
  logic [31:0] core_b;

  logic [31:0] a_tbl   [4];
  logic [31:0] b_tbl   [4];
  logic        sub_tbl [4];
  logic [31:0] res_tbl [4];
  int          exp_ord [8];

  fp_add_arbiter_if #(.N_REQ(N)) ifc ();

  fp_add_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed FP32 sums for every operand pair the bench issues.
  function automatic logic [31:0] core_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1+2=3
      {32'h4040_0000, 32'hBF80_0000}: return 32'h4000_0000; // 3-1=2
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000; // 1+1=2
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000; // 2+2=4
      {32'h4080_0000, 32'hBF80_0000}: return 32'h4040_0000; // 4-1=3
      {32'h3F00_0000, 32'h3F00_0000}: return 32'h3F80_0000; // .5+.5=1
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Core stub: finish drops on start, rises CORE_LAT cycles later, stays high.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ifc.fpu_finish <= 1'b0;
      ifc.fpu_result <= '0;
      core_cnt       <= 0;
    end else if (ifc.fpu_start) begin
      ifc.fpu_finish <= 1'b0;
      core_cnt       <= core_hang ? 0 : CORE_LAT;
      core_a         <= ifc.fpu_a;
      core_b         <= ifc.fpu_b;
    end else if (core_cnt == 1) begin
      ifc.fpu_finish <= 1'b1;
      ifc.fpu_result <= core_sum(core_a, core_b);
      core_cnt       <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] t;
    t = 4'b0001;
    return t << i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_rdy"},  32'(ifc.req_ready), 0);
    chk({tag, "_rspv"}, 32'(ifc.resp_valid), 0);
    chk({tag, "_rspd"}, ifc.resp_data, 0);
    chk({tag, "_rspt"}, 32'(ifc.resp_timeout), 0);
    chk({tag, "_busy"}, 32'(ifc.busy), 0);
    chk({tag, "_strt"}, 32'(ifc.fpu_start), 0);
    chk({tag, "_fa"},   ifc.fpu_a, 0);
    chk({tag, "_fb"},   ifc.fpu_b, 0);
  endtask

  // Single request; exp_lat = samples from the ISSUE cycle to the RESP cycle.
  task automatic do_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] exp_b, input logic [31:0] exp_d,
                        input logic exp_to, input int exp_lat, input string tag);
    int  st_cyc, rs_cyc, n_st, n_rdy;
    bit  got;
    got = 0; n_st = 0; n_rdy = 0; st_cyc = 0; rs_cyc = 0;
    ifc.req_a[32*idx +: 32] = a;
    ifc.req_b[32*idx +: 32] = b;
    ifc.req_sub[idx]        = sub;
    ifc.req_valid[idx]      = 1'b1;
    for (int c = 1; c <= 40 && !got; c++) begin
      step();
      if (ifc.fpu_start) begin
        n_st++;
        st_cyc = c;
        chk({tag, "_fpu_a"}, ifc.fpu_a, a);
        chk({tag, "_fpu_b"}, ifc.fpu_b, exp_b);
        chk({tag, "_busy"},  32'(ifc.busy), 1);
      end
      if (ifc.req_ready != 0) begin
        n_rdy++;
        chk({tag, "_rdy"}, 32'(ifc.req_ready), 32'(oh(idx)));
        ifc.req_valid[idx] = 1'b0;
      end
      if (ifc.resp_valid != 0) begin
        got    = 1;
        rs_cyc = c;
        chk({tag, "_rspv"}, 32'(ifc.resp_valid), 32'(oh(idx)));
        chk({tag, "_data"}, ifc.resp_data, exp_d);
        chk({tag, "_tmo"},  32'(ifc.resp_timeout), 32'(exp_to));
      end
    end
    chk({tag, "_resp_seen"}, 32'(got), 1);
    chk({tag, "_n_start"},   n_st, 1);
    chk({tag, "_n_ready"},   n_rdy, 1);
    chk({tag, "_lat"},       rs_cyc - st_cyc, exp_lat);
    step();
    chk({tag, "_idle"}, 32'(ifc.busy), 0);
  endtask

  // All requesters in mask held valid from table operands until n grants seen;
  // grant/response order must follow exp_ord.
  task automatic run_multi(input logic [3:0] mask, input int n, input string tag);
    int n_rdy, n_rsp, n_st;
    n_rdy = 0; n_rsp = 0; n_st = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        ifc.req_a[32*i +: 32] = a_tbl[i];
        ifc.req_b[32*i +: 32] = b_tbl[i];
        ifc.req_sub[i]        = sub_tbl[i];
      end
    end
    ifc.req_valid = mask;
    for (int c = 0; c < 200 && n_rsp < n; c++) begin
      step();
      if (ifc.fpu_start) n_st++;
      if (ifc.req_ready != 0 && n_rdy < 8) begin
        chk({tag, "_rdy"}, 32'(ifc.req_ready), 32'(oh(exp_ord[n_rdy])));
        n_rdy++;
        if (n_rdy == n) ifc.req_valid = '0;
      end
      if (ifc.resp_valid != 0 && n_rsp < 8) begin
        chk({tag, "_rspv"},  32'(ifc.resp_valid), 32'(oh(exp_ord[n_rsp])));
        chk({tag, "_data"},  ifc.resp_data, res_tbl[exp_ord[n_rsp]]);
        chk({tag, "_tmo"},   32'(ifc.resp_timeout), 0);
        chk({tag, "_nstrt"}, n_st, 1);
        n_st = 0;
        n_rsp++;
      end
    end
    chk({tag, "_n_resp"}, n_rsp, n);
    step();
    chk({tag, "_idle"}, 32'(ifc.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bad3, n_rv;
    bit  seen_st, got;
    n_tests = 0; n_fail = 0; core_hang = 0;
    a_tbl[0] = 32'h3F80_0000; b_tbl[0] = 32'h3F80_0000; sub_tbl[0] = 0; res_tbl[0] = 32'h4000_0000;
    a_tbl[1] = 32'h4000_0000; b_tbl[1] = 32'h4000_0000; sub_tbl[1] = 0; res_tbl[1] = 32'h4080_0000;
    a_tbl[2] = 32'h4080_0000; b_tbl[2] = 32'h3F80_0000; sub_tbl[2] = 1; res_tbl[2] = 32'h4040_0000;
    a_tbl[3] = 32'h3F00_0000; b_tbl[3] = 32'h3F00_0000; sub_tbl[3] = 0; res_tbl[3] = 32'h3F80_0000;
    ifc.req_valid = '0; ifc.req_sub = '0; ifc.req_a = '0; ifc.req_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("rst0");
    #2 rst = 1'b0;

    // 1: 1.0 + 2.0
    do_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000, 1'b0, CORE_LAT + 2, "t1");
    // 2: 3.0 - 1.0, B sign flipped on the way to the core
    do_req(1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h4000_0000, 1'b0, CORE_LAT + 2, "t2");

    // 3: pointer is 2 here; reset must bring it back to 0
    step(); rst = 1'b1; #2 rst = 1'b0;
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 2; exp_ord[3] = 3; exp_ord[4] = 0;
    run_multi(4'b1111, 5, "t3");

    // 4: core hangs -> timeout after TMO WAIT cycles (ISSUE + TMO WAIT + RESP)
    core_hang = 1;
    do_req(2, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, TMO + 1, "t4");
    core_hang = 0;
    do_req(3, 32'h3F00_0000, 32'h3F00_0000, 1'b0, 32'h3F00_0000, 32'h3F80_0000, 1'b0, CORE_LAT + 2, "t4n");

    // 5: pointer to 1, then reset while req2's job is in WAIT
    do_req(0, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4080_0000, 1'b0, CORE_LAT + 2, "t5p");
    ifc.req_a[64 +: 32] = a_tbl[2]; ifc.req_b[64 +: 32] = b_tbl[2]; ifc.req_sub[2] = sub_tbl[2];
    ifc.req_valid[2] = 1'b1;
    seen_st = 0;
    for (int c = 0; c < 20 && !seen_st; c++) begin
      step();
      if (ifc.fpu_start) seen_st = 1;
      if (ifc.req_ready != 0) ifc.req_valid[2] = 1'b0;
    end
    chk("t5_start_seen", 32'(seen_st), 1);
    step();
    chk("t5_busy_wait", 32'(ifc.busy), 1);
    rst = 1'b1;
    #1;
    chk_zero_outs("t5rst");
    ifc.req_valid = '0;
    step();
    #3 rst = 1'b0;
    n_rv = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ifc.resp_valid != 0 || ifc.busy) n_rv++;
    end
    chk("t5_no_resp", n_rv, 0);
    // pointer back at 0: req0 beats req2 (pointer 1 would pick 2 first)
    exp_ord[0] = 0; exp_ord[1] = 2;
    run_multi(4'b0101, 2, "t5");

    // 6: pointer 3 -> serve req3 to bring it to 0, then req3 withdraws during req0 WAIT
    do_req(3, a_tbl[3], b_tbl[3], 1'b0, b_tbl[3], res_tbl[3], 1'b0, CORE_LAT + 2, "t6p");
    ifc.req_a[0 +: 32] = a_tbl[0]; ifc.req_b[0 +: 32] = b_tbl[0]; ifc.req_sub[0] = 0;
    ifc.req_a[96 +: 32] = a_tbl[3]; ifc.req_b[96 +: 32] = b_tbl[3]; ifc.req_sub[3] = 0;
    ifc.req_valid = 4'b1001;
    bad3 = 0; seen_st = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (ifc.req_ready[3] || ifc.resp_valid[3]) bad3++;
      if (ifc.req_ready != 0) begin
        chk("t6_rdy", 32'(ifc.req_ready), 32'b0001);
        ifc.req_valid[0] = 1'b0;
      end
      if (seen_st) ifc.req_valid[3] = 1'b0;
      if (ifc.fpu_start) seen_st = 1;
      if (ifc.resp_valid != 0) begin
        got = 1;
        chk("t6_rspv", 32'(ifc.resp_valid), 32'b0001);
        chk("t6_data", ifc.resp_data, res_tbl[0]);
      end
    end
    chk("t6_resp_seen", 32'(got), 1);
    for (int c = 0; c < 8; c++) begin
      step();
      if (ifc.req_ready != 0 || ifc.resp_valid != 0 || ifc.busy) bad3++;
    end
    chk("t6_req3_silent", bad3, 0);
    // pointer now 1: req1 ahead of req0
    exp_ord[0] = 1; exp_ord[1] = 0;
    run_multi(4'b0011, 2, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
